// File: rtl/sync_fifo_cfg.sv
// rtl/sync_fifo_cfg.sv - single-clock FIFO, any depth >= 2, optional FWFT, threshold flags, sticky errors
module sync_fifo_cfg #(
  parameter int WIDTH     = 9,
  parameter int DEPTH     = 512,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       srst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_cfg: DEPTH must be at least 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_cfg: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_cfg: AE_THRESH must be in 0..DEPTH-1");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_write;
  logic             do_read;

  // Every flag is a pure decode of count so they can never disagree.
  assign full         = (count == CNT_FULL);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  assign do_write = wr_en && !full;
  assign do_read  = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (srst_n && do_write) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_read) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Set has priority over clear so a fault in the clearing cycle is not lost.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dout = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (!srst_n) begin
          dout <= '0;
        end else if (do_read) begin
          dout <= mem[rd_ptr];
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_cfg.sv
// tb/tb_sync_fifo_cfg.sv - bench for sync_fifo_cfg: three configurations against a queue model
module tb_sync_fifo_cfg;
  logic       clk = 1'b0;
  logic       srst_n;
  logic       wr [3];
  logic       rd [3];
  logic       clr [3];
  logic [7:0] din [3];
  logic [7:0] dout_a [3];
  logic       full_a [3];
  logic       af_a [3];
  logic       empty_a [3];
  logic       ae_a [3];
  logic       ovf_a [3];
  logic       unf_a [3];
  logic [2:0] count0;
  logic [2:0] count1;
  logic [3:0] count2;
  int         cnt_a [3];

  int nvec = 0;
  int nerr = 0;
  bit checking = 1'b0;

  int dep  [3] = '{5, 5, 8};
  int fwft [3] = '{0, 1, 0};
  int af_t [3] = '{4, 4, 6};
  int ae_t [3] = '{1, 1, 2};

  always #5 clk = ~clk;

  sync_fifo_cfg #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u_reg5 (
    .clk(clk), .srst_n(srst_n), .wr_en(wr[0]), .din(din[0]), .full(full_a[0]),
    .almost_full(af_a[0]), .rd_en(rd[0]), .dout(dout_a[0]), .empty(empty_a[0]),
    .almost_empty(ae_a[0]), .count(count0), .overflow(ovf_a[0]), .underflow(unf_a[0]),
    .clr_err(clr[0])
  );

  sync_fifo_cfg #(.WIDTH(8), .DEPTH(5), .FWFT(1)) u_fwft5 (
    .clk(clk), .srst_n(srst_n), .wr_en(wr[1]), .din(din[1]), .full(full_a[1]),
    .almost_full(af_a[1]), .rd_en(rd[1]), .dout(dout_a[1]), .empty(empty_a[1]),
    .almost_empty(ae_a[1]), .count(count1), .overflow(ovf_a[1]), .underflow(unf_a[1]),
    .clr_err(clr[1])
  );

  sync_fifo_cfg #(.WIDTH(8), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)) u_thr8 (
    .clk(clk), .srst_n(srst_n), .wr_en(wr[2]), .din(din[2]), .full(full_a[2]),
    .almost_full(af_a[2]), .rd_en(rd[2]), .dout(dout_a[2]), .empty(empty_a[2]),
    .almost_empty(ae_a[2]), .count(count2), .overflow(ovf_a[2]), .underflow(unf_a[2]),
    .clr_err(clr[2])
  );

  always_comb begin
    cnt_a[0] = int'(count0);
    cnt_a[1] = int'(count1);
    cnt_a[2] = int'(count2);
  end

  // Model: one queue of tagged entries {instance, data}; each instance sees its own subsequence.
  logic [9:0] mq [$];
  logic [7:0] mdout [3];
  logic       movf [3];
  logic       munf [3];

  function automatic int m_count(input int i);
    int n = 0;
    foreach (mq[k]) if (mq[k][9:8] == 2'(i)) n++;
    return n;
  endfunction

  function automatic int m_head(input int i);
    foreach (mq[k]) if (mq[k][9:8] == 2'(i)) return k;
    return -1;
  endfunction

  int   mc, mh;
  logic mw, mr;
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      mc = m_count(i);
      mh = m_head(i);
      if (!srst_n) begin
        for (int k = mq.size() - 1; k >= 0; k--) if (mq[k][9:8] == 2'(i)) mq.delete(k);
        mdout[i] = 8'h00;
        movf[i]  = 1'b0;
        munf[i]  = 1'b0;
      end else begin
        mw = wr[i] && (mc != dep[i]);
        mr = rd[i] && (mc != 0);
        if (mr) begin
          if (fwft[i] == 0) mdout[i] = mq[mh][7:0];
          mq.delete(mh);
        end
        if (mw) mq.push_back({2'(i), din[i]});
        if (wr[i] && mc == dep[i]) movf[i] = 1'b1;
        else if (clr[i]) movf[i] = 1'b0;
        if (rd[i] && mc == 0) munf[i] = 1'b1;
        else if (clr[i]) munf[i] = 1'b0;
      end
    end
  end

  task automatic cmp(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, i, act, exp);
    end
  endtask

  int         ec, eh;
  logic [7:0] ed;
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        ec = m_count(i);
        eh = m_head(i);
        if (fwft[i] != 0) ed = (ec == 0) ? 8'h00 : mq[eh][7:0];
        else ed = mdout[i];
        cmp("count", i, cnt_a[i], ec);
        cmp("empty", i, empty_a[i], ec == 0);
        cmp("full", i, full_a[i], ec == dep[i]);
        cmp("almost_full", i, af_a[i], ec >= af_t[i]);
        cmp("almost_empty", i, ae_a[i], ec <= ae_t[i]);
        cmp("overflow", i, ovf_a[i], movf[i]);
        cmp("underflow", i, unf_a[i], munf[i]);
        cmp("dout", i, dout_a[i], ed);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    srst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr[i] = 1'b0; rd[i] = 1'b0; clr[i] = 1'b0; din[i] = 8'h00;
    end
    tick(); tick();
    srst_n = 1'b1;
    checking = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      cmp("rst_empty", i, empty_a[i], 1);
      cmp("rst_almost_empty", i, ae_a[i], 1);
      cmp("rst_count", i, cnt_a[i], 0);
      cmp("rst_dout", i, dout_a[i], 0);
      cmp("rst_full", i, full_a[i], 0);
      cmp("rst_overflow", i, ovf_a[i], 0);
      cmp("rst_underflow", i, unf_a[i], 0);
    end

    // Registered mode, depth 5: fill, overfill, drain, twice to wrap the pointers.
    for (int pass = 0; pass < 2; pass++) begin
      wr[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
        din[0] = 8'((pass == 0 ? 8'h11 : 8'h21) + k);
        tick();
      end
      din[0] = 8'h99;
      tick();
      wr[0] = 1'b0;
      cmp("fill_full", 0, full_a[0], 1);
      cmp("fill_overflow", 0, ovf_a[0], 1);
      cmp("fill_count", 0, cnt_a[0], 5);
      rd[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
        tick();
        cmp("drain_dout", 0, dout_a[0], 8'((pass == 0 ? 8'h11 : 8'h21) + k));
      end
      rd[0] = 1'b0;
      cmp("drain_empty", 0, empty_a[0], 1);
      clr[0] = 1'b1;
      tick();
      clr[0] = 1'b0;
      cmp("clr_overflow", 0, ovf_a[0], 0);
    end

    // FWFT: head visible the cycle after the write, cleared to 0 after the pop.
    wr[1] = 1'b1; din[1] = 8'hA5;
    tick();
    wr[1] = 1'b0;
    cmp("fwft_empty", 1, empty_a[1], 0);
    cmp("fwft_dout", 1, dout_a[1], 8'hA5);
    rd[1] = 1'b1;
    tick();
    rd[1] = 1'b0;
    cmp("fwft_pop_empty", 1, empty_a[1], 1);
    cmp("fwft_pop_dout", 1, dout_a[1], 0);

    // Thresholds AF=6, AE=2 on depth 8.
    wr[2] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      din[2] = 8'(k);
      tick();
      cmp("up_almost_empty", 2, ae_a[2], k <= 2);
      cmp("up_almost_full", 2, af_a[2], k >= 6);
    end
    wr[2] = 1'b0;
    rd[2] = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      tick();
      cmp("down_almost_empty", 2, ae_a[2], k <= 2);
      cmp("down_almost_full", 2, af_a[2], k >= 6);
    end
    rd[2] = 1'b0;

    // Simultaneous read/write at count 3 for 20 cycles.
    wr[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din[2] = 8'(8'h30 + k);
      tick();
    end
    rd[2] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      din[2] = 8'(8'h40 + k);
      tick();
      cmp("rw_count", 2, cnt_a[2], 3);
    end
    wr[2] = 1'b0;
    cmp("rw_last_dout", 2, dout_a[2], 8'h50);
    for (int k = 0; k < 3; k++) begin
      tick();
      cmp("rw_tail_dout", 2, dout_a[2], 8'(8'h51 + k));
    end

    // Simultaneous at empty: only the write lands.
    wr[2] = 1'b1; din[2] = 8'h77;
    tick();
    rd[2] = 1'b0;
    cmp("rw_empty_count", 2, cnt_a[2], 1);
    cmp("rw_empty_underflow", 2, unf_a[2], 1);
    for (int k = 0; k < 7; k++) begin
      din[2] = 8'(8'h80 + k);
      tick();
    end
    cmp("refill_count", 2, cnt_a[2], 8);
    rd[2] = 1'b1; din[2] = 8'hCC;
    tick();
    wr[2] = 1'b0;
    cmp("rw_full_count", 2, cnt_a[2], 7);
    cmp("rw_full_overflow", 2, ovf_a[2], 1);
    cmp("rw_full_dout", 2, dout_a[2], 8'h77);
    tick(); tick(); tick();
    rd[2] = 1'b0;
    cmp("pre_reset_count", 2, cnt_a[2], 4);

    // Set wins over clear, then clear alone.
    rd[0] = 1'b1; clr[0] = 1'b1;
    tick();
    rd[0] = 1'b0;
    cmp("set_wins_underflow", 0, unf_a[0], 1);
    tick();
    clr[0] = 1'b0;
    cmp("clr_underflow", 0, unf_a[0], 0);

    // Reset beats a concurrent write.
    srst_n = 1'b0; wr[2] = 1'b1; din[2] = 8'hEE;
    tick();
    srst_n = 1'b1; wr[2] = 1'b0;
    cmp("mid_reset_count", 2, cnt_a[2], 0);
    cmp("mid_reset_empty", 2, empty_a[2], 1);
    cmp("mid_reset_overflow", 2, ovf_a[2], 0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
